// File: rtl/sram_pkg.sv
// Shared types and constants for the banked SRAM array and its port controller.
package sram_pkg;

   localparam int SRAM_WIDTH     = 512;
   localparam int SRAM_ROW_W     = 9;
   localparam int SRAM_WORD_SIZE = 64;
   localparam int SRAM_ID_W      = 4;
   localparam int SRAM_RSP_DEPTH = 2;

   function automatic int numWords(input int width, input int wordSize);
      return width / wordSize;
   endfunction

   typedef struct packed {
      logic [SRAM_ID_W-1:0]  id;
      logic [SRAM_WIDTH-1:0] data;
   } rsp_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small in-order response queue; push/pop at the same edge is legal even when full.
module sram_rsp_fifo
   import sram_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         pushValid,
   input  rsp_t                         pushData,
   input  logic                         popReady,
   output logic                         popValid,
   output rsp_t                         popData,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   rsp_t          mem [DEPTH];
   logic [PW-1:0] wrPtr;
   logic [PW-1:0] rdPtr;
   logic          pop;

   assign popValid = (count != '0);
   assign pop      = popValid & popReady;
   assign popData  = mem[rdPtr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (pushValid) wrPtr <= wrPtr + 1'b1;
         if (pop)       rdPtr <= rdPtr + 1'b1;
         count <= count + CW'(pushValid) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (pushValid) mem[wrPtr] <= pushData;
   end

endmodule

// File: rtl/sram_port_ctrl.sv
// Request/response front end for the banked SRAM: 0-latency writes, 2-cycle reads
// with same-edge write forwarding and credit-limited response queue.
module sram_port_ctrl
   import sram_pkg::*;
#(
   parameter int WIDTH        = SRAM_WIDTH,
   parameter int LOG_NUM_ROWS = SRAM_ROW_W,
   parameter int WORD_SIZE    = SRAM_WORD_SIZE,
   parameter int ID_W         = SRAM_ID_W,
   parameter int RSP_DEPTH    = SRAM_RSP_DEPTH,
   localparam int NW          = numWords(WIDTH, WORD_SIZE)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    rd_valid,
   output logic                    rd_ready,
   input  logic [LOG_NUM_ROWS-1:0] rd_addr,
   input  logic [ID_W-1:0]         rd_id,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [LOG_NUM_ROWS-1:0] wr_addr,
   input  logic [WIDTH-1:0]        wr_data,
   input  logic [NW-1:0]           wr_be,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [WIDTH-1:0]        rsp_data,
   output logic [ID_W-1:0]         rsp_id,
   output logic [LOG_NUM_ROWS-1:0] sram_raddr,
   input  logic [WIDTH-1:0]        sram_rdata,
   output logic [LOG_NUM_ROWS-1:0] sram_waddr,
   output logic [WIDTH-1:0]        sram_wdata,
   output logic [NW-1:0]           sram_we
);

   localparam int CW = $clog2(RSP_DEPTH+1);
   localparam logic [CW:0] DEPTH_C = (CW+1)'(RSP_DEPTH);

   logic             live;
   logic             wrAcc;
   logic             rdAcc;
   logic             pop;
   logic             inflight;
   logic [ID_W-1:0]  idQ;
   logic [NW-1:0]    fwdBeQ;
   logic [WIDTH-1:0] fwdDataQ;
   logic [WIDTH-1:0] merged;
   logic [CW-1:0]    fifoCount;
   logic [CW:0]      credUsed;
   rsp_t             pushRsp;
   rsp_t             headRsp;

   assign sram_raddr = rd_addr;
   assign sram_waddr = wr_addr;
   assign sram_wdata = wr_data;

   assign wr_ready = live;
   assign wrAcc    = wr_valid & live;
   assign rdAcc    = rd_valid & rd_ready;
   assign sram_we  = wrAcc ? wr_be : '0;

   // A pop this cycle frees a slot in time for a read accepted at the same edge.
   assign pop      = rsp_valid & rsp_ready;
   assign credUsed = (CW+1)'(fifoCount) + (CW+1)'(inflight) - (CW+1)'(pop);
   assign rd_ready = live & (credUsed < DEPTH_C);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         live     <= 1'b0;
         inflight <= 1'b0;
         fwdBeQ   <= '0;
      end else begin
         live     <= 1'b1;
         inflight <= rdAcc;
         if (rdAcc)
            fwdBeQ <= (wrAcc && wr_addr == rd_addr) ? wr_be : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rdAcc) begin
         idQ      <= rd_id;
         fwdDataQ <= wr_data;
      end
   end

   always_comb begin
      merged = sram_rdata;
      for (int i = 0; i < NW; i++) begin
         if (fwdBeQ[i])
            merged[i*WORD_SIZE +: WORD_SIZE] = fwdDataQ[i*WORD_SIZE +: WORD_SIZE];
      end
   end

   assign pushRsp = '{id: idQ, data: merged};

   sram_rsp_fifo #(
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .reset     (reset),
      .pushValid (inflight),
      .pushData  (pushRsp),
      .popReady  (rsp_ready),
      .popValid  (rsp_valid),
      .popData   (headRsp),
      .count     (fifoCount)
   );

   assign rsp_data = headRsp.data;
   assign rsp_id   = headRsp.id;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Randomised bench for sram_port_ctrl against a row-level memory and response-queue model.
module tb_sram_port_ctrl;

   localparam int W     = 512;
   localparam int AW    = 9;
   localparam int NW    = 8;
   localparam int IW    = 4;
   localparam int DEPTH = 2;
   localparam int ROWS  = 512;

   logic          clk;
   logic          reset;
   logic          rdValid;
   logic          rdReady;
   logic [AW-1:0] rdAddr;
   logic [IW-1:0] rdId;
   logic          wrValid;
   logic          wrReady;
   logic [AW-1:0] wrAddr;
   logic [W-1:0]  wrData;
   logic [NW-1:0] wrBe;
   logic          rspValid;
   logic          rspReady;
   logic [W-1:0]  rspData;
   logic [IW-1:0] rspId;
   logic [AW-1:0] sramRaddr;
   logic [W-1:0]  sramRdata;
   logic [AW-1:0] sramWaddr;
   logic [W-1:0]  sramWdata;
   logic [NW-1:0] sramWe;

   sram_port_ctrl #(
      .WIDTH        (W),
      .LOG_NUM_ROWS (AW),
      .WORD_SIZE    (64),
      .ID_W         (IW),
      .RSP_DEPTH    (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rd_valid   (rdValid),
      .rd_ready   (rdReady),
      .rd_addr    (rdAddr),
      .rd_id      (rdId),
      .wr_valid   (wrValid),
      .wr_ready   (wrReady),
      .wr_addr    (wrAddr),
      .wr_data    (wrData),
      .wr_be      (wrBe),
      .rsp_valid  (rspValid),
      .rsp_ready  (rspReady),
      .rsp_data   (rspData),
      .rsp_id     (rspId),
      .sram_raddr (sramRaddr),
      .sram_rdata (sramRdata),
      .sram_waddr (sramWaddr),
      .sram_wdata (sramWdata),
      .sram_we    (sramWe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Array model: registered read returns the pre-write row on a same-edge collision.
   logic [W-1:0] sram [ROWS];
   always @(posedge clk) begin
      sramRdata <= sram[sramRaddr];
      for (int i = 0; i < NW; i++)
         if (sramWe[i]) sram[sramWaddr][i*64 +: 64] <= sramWdata[i*64 +: 64];
   end

   logic [W-1:0]  refMem [ROWS];
   logic [IW-1:0] qId   [$];
   logic [W-1:0]  qData [$];
   int            qAt   [$];
   int nCmp = 0;
   int nBad = 0;
   int cyc  = 0;
   int nRdAcc = 0;
   int nPop = 0;
   bit live = 1'b0;
   int base;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      nCmp++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   task automatic evalCycle();
      bit expValid, popE, expRd, rdAcc, wrAcc;
      int sz;
      sz       = qId.size();
      expValid = (sz > 0) && (qAt[0] <= cyc);
      popE     = expValid && rspReady;
      expRd    = live && ((sz - int'(popE)) < DEPTH);
      check("rspValid", W'(rspValid), W'(expValid));
      if (popE) begin
         check("rspId", W'(rspId), W'(qId[0]));
         check("rspData", rspData, qData[0]);
         void'(qId.pop_front());
         void'(qData.pop_front());
         void'(qAt.pop_front());
         nPop++;
      end
      check("rdReady", W'(rdReady), W'(expRd));
      check("wrReady", W'(wrReady), W'(live));
      check("sramWe", W'(sramWe), W'((wrValid && live) ? wrBe : 8'h00));
      wrAcc = wrValid && live;
      rdAcc = rdValid && expRd;
      if (wrAcc)
         for (int i = 0; i < NW; i++)
            if (wrBe[i]) refMem[wrAddr][i*64 +: 64] = wrData[i*64 +: 64];
      if (rdAcc) begin
         qId.push_back(rdId);
         qData.push_back(refMem[rdAddr]);
         qAt.push_back(cyc + 2);
         nRdAcc++;
      end
      cyc++;
   endtask

   task automatic tick();
      @(negedge clk);
      evalCycle();
      @(posedge clk);
      if (reset) live = 1'b1;
      #1;
   endtask

   task automatic idle();
      rdValid = 1'b0;
      wrValid = 1'b0;
   endtask

   task automatic setWrite(input int row, input logic [NW-1:0] be, input logic [W-1:0] d);
      wrValid = 1'b1;
      wrAddr  = AW'(row);
      wrBe    = be;
      wrData  = d;
   endtask

   task automatic setRead(input int row, input int id);
      rdValid = 1'b1;
      rdAddr  = AW'(row);
      rdId    = IW'(id);
   endtask

   function automatic logic [W-1:0] randRow();
      logic [W-1:0] r;
      for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   initial begin
      for (int i = 0; i < ROWS; i++) begin
         sram[i]   = '0;
         refMem[i] = '0;
      end
      reset = 1'b0; rspReady = 1'b1;
      idle();
      rdAddr = '0; rdId = '0; wrAddr = '0; wrData = '0; wrBe = '0;
      #1;
      check("rstRspValid", W'(rspValid), W'(0));
      check("rstRdReady", W'(rdReady), W'(0));
      check("rstWrReady", W'(wrReady), W'(0));
      tick(); tick();
      @(posedge clk); #1;
      reset = 1'b1;
      tick();
      check("wrReadyUp", W'(wrReady), W'(1));

      // 1: write then read next edge, 2-cycle latency
      setWrite(5, 8'hFF, {64{8'hA5}}); tick();
      idle(); setRead(5, 3); tick();
      idle(); tick(); tick(); tick();

      // 2: same-edge collision forwards the written word
      setWrite(7, 8'hFF, '0); tick();
      setWrite(7, 8'h01, {W{1'b1}}); setRead(7, 9); tick();
      idle(); tick(); tick(); tick();

      // 3: back-to-back reads
      base = nRdAcc;
      for (int i = 0; i < 16; i++) begin
         setRead($urandom_range(0, 15), i);
         tick();
      end
      idle(); tick(); tick(); tick();
      check("b2bAccepted", W'(nRdAcc - base), W'(16));

      // 4: stalled consumer limits acceptance to the queue depth
      rspReady = 1'b0;
      base = nRdAcc;
      for (int i = 0; i < 5; i++) begin
         setRead(i, i);
         tick();
      end
      check("stallAccepted", W'(nRdAcc - base), W'(DEPTH));
      rspReady = 1'b1;
      #2;
      check("rdReadyRecover", W'(rdReady), W'(1));
      tick();
      idle(); tick(); tick(); tick(); tick();

      // 5: reset with one inflight read and one queued response
      rspReady = 1'b0;
      setRead(1, 1); tick();
      setRead(2, 2); tick();
      setWrite(3, 8'hFF, randRow());
      reset = 1'b0; live = 1'b0;
      #1;
      check("midRstRspValid", W'(rspValid), W'(0));
      check("midRstRdReady", W'(rdReady), W'(0));
      check("midRstWrReady", W'(wrReady), W'(0));
      check("midRstSramWe", W'(sramWe), W'(0));
      qId.delete(); qData.delete(); qAt.delete();
      tick(); tick();
      reset = 1'b1;
      idle(); rspReady = 1'b1;
      for (int i = 0; i < 5; i++) tick();

      // 6: empty byte-enable write is a no-op
      setWrite(2, 8'hFF, randRow()); tick();
      setWrite(2, 8'h00, randRow()); tick();
      idle(); setRead(2, 6); tick();
      idle(); tick(); tick(); tick();

      // random traffic over a small row range to provoke collisions
      for (int n = 0; n < 800; n++) begin
         rdValid  = 1'($urandom_range(0, 3) != 0);
         rdAddr   = AW'($urandom_range(0, 7));
         rdId     = IW'($urandom);
         wrValid  = 1'($urandom_range(0, 1));
         wrAddr   = AW'($urandom_range(0, 7));
         wrBe     = NW'($urandom);
         wrData   = randRow();
         rspReady = 1'($urandom_range(0, 3) != 0);
         tick();
      end
      idle(); rspReady = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      check("drained", W'(qId.size()), W'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
